// File: rtl/imul_pkg.sv
// rtl/imul_pkg.sv - shared state encoding and default width for the IMUL sequencer
package imul_pkg;

    localparam int IMUL_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IMUL_IDLE = 2'd0,
        IMUL_RUN  = 2'd1,
        IMUL_DONE = 2'd2
    } imul_state_e;

endpackage

// File: rtl/imul_ripple_adder.sv
// rtl/imul_ripple_adder.sv - N-bit ripple-carry adder of 1-bit full-adder cells, carry-out dropped
module imul_ripple_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] sum_o
);

    // carry[i] is the carry into bit i; the final carry-out is never formed
    logic [N-1:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ carry[i];
        if (i < N - 1) begin : g_carry
            assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end

endmodule

// File: rtl/imul_seq_ctrl.sv
// rtl/imul_seq_ctrl.sv - shift-and-add multiplier controller; IMUL_EARLY_EXIT_EN enables early exit
module imul_seq_ctrl
    import imul_pkg::*;
#(
    parameter int WIDTH = IMUL_WIDTH_DEFAULT
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iStart,
    input  logic [WIDTH-1:0]   iA,
    input  logic [WIDTH-1:0]   iB,
    input  logic               iAck,
    output logic               oReady,
    output logic               oBusy,
    output logic               oDone,
    output logic [2*WIDTH-1:0] oResult
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    imul_state_e       state_q;
    logic [CW-1:0]     cnt_q;
    logic [PW-1:0]     a_q;
    logic [WIDTH-1:0]  b_q;
    logic [PW-1:0]     p_q;
    logic [PW-1:0]     p_d;
    logic [PW-1:0]     sum;
    logic [PW-1:0]     result_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              last_iter;

    imul_ripple_adder #(.N(PW)) u_adder (
        .a_i   (p_q),
        .b_i   (a_q),
        .sum_o (sum)
    );

    always_comb begin
        p_d = b_q[0] ? sum : p_q;
`ifdef IMUL_EARLY_EXIT_EN
        // remaining multiplier bits all zero: further iterations add nothing
        last_iter = (cnt_q == LAST_CNT) || (b_q[WIDTH-1:1] == '0);
`else
        last_iter = (cnt_q == LAST_CNT);
`endif
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IMUL_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            result_q <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IMUL_IDLE: begin
                    if (iStart) begin
                        a_q     <= {{WIDTH{1'b0}}, iA};
                        b_q     <= iB;
                        p_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= IMUL_RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                IMUL_RUN: begin
                    p_q   <= p_d;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_iter) begin
                        result_q <= p_d;
                        state_q  <= IMUL_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                IMUL_DONE: begin
                    if (iAck) begin
                        state_q <= IMUL_IDLE;
                        done_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IMUL_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign oReady  = ready_q;
    assign oBusy   = busy_q;
    assign oDone   = done_q;
    assign oResult = result_q;

endmodule

// File: doc/imul_seq_ctrl.md
# imul_seq_ctrl

Iterative shift-and-add unsigned multiplier controller for the IMUL datapath. It accepts two WIDTH-bit operands through a ready/start handshake and sequences one partial-product accumulation per clock. It presents the 2·WIDTH-bit product behind a done/ack handshake. It sits between the operand-issuing logic and the result consumer, and owns the bit counter, operand shift registers and accumulator.

## Interface
- WIDTH, 4, operand width in bits; legal range ≥2.
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- iStart  in  1  request; sampled only while oReady=1.
- iA  in  WIDTH  multiplicand; sampled on the accepted iStart edge.
- iB  in  WIDTH  multiplier; sampled on the accepted iStart edge.
- iAck  in  1  consumer acknowledge; sampled only while oDone=1.
- oReady  out  1  high in IDLE.
- oBusy  out  1  high in RUN.
- oDone  out  1  high in DONE; oResult valid.
- oResult  out  2·WIDTH  product register.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- IDLE: oReady=1. On iStart=1 the block loads:
  - A_reg = zero-extended iA (2·WIDTH bits).
  - B_reg = iB.
  - P = 0.
  - cnt = 0.
  - Next state RUN.
- RUN, one iteration per cycle:
  - If B_reg[0], P = P + A_reg. The sum is truncated to 2·WIDTH bits and cannot overflow.
  - A_reg <<= 1; B_reg >>= 1; cnt++.
  - Terminates on the iteration where cnt reaches WIDTH−1 (after WIDTH iterations). See Configuration for early exit.
  - On the terminating edge, oResult ← final P and the state goes to DONE.
- DONE: oDone=1, oResult held. On iAck=1 the state goes to IDLE.
- oResult changes only on the RUN→DONE edge. It holds the last product through IDLE and the next RUN.
- Ignored inputs:
  - iStart outside IDLE has no effect.
  - iAck outside DONE has no effect.
  - In DONE with iStart=1 and iAck=1 together, only the ack acts; start must be re-asserted in IDLE.
- Reset asserted mid-RUN or in DONE aborts immediately. The partial product is discarded.
- Counter width: $clog2(WIDTH).

## Timing
- Reset values: oReady=1, oBusy=0, oDone=0, oResult=0, state IDLE, cnt=0, A_reg=B_reg=P=0. These apply asynchronously while Reset=0.
- Start accepted at edge E0.
  - oBusy=1 after E0.
  - Without early exit, oDone=1 after edge E0+WIDTH, i.e. fixed latency of WIDTH cycles.
- iAck sampled high at edge Ek: oReady=1 after Ek. The earliest next start is accepted at Ek+1.
- Minimum op period: WIDTH+2 cycles.
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: IMUL_EARLY_EXIT_EN.
- Defined: RUN also terminates on any iteration whose post-shift B_reg equals 0.
  - The result is unchanged.
  - Latency becomes max(1, index of iB's highest set bit + 1) cycles.
  - iB=0 gives 1 cycle.
- Undefined: latency is always exactly WIDTH cycles, independent of operands.

## Structure
- Shared package imul_pkg holds:
  - the state encoding constants IMUL_IDLE, IMUL_RUN, IMUL_DONE (2-bit);
  - the default width constant IMUL_WIDTH_DEFAULT = 4.
- One sub-module, imul_ripple_adder:
  - parameterized 2·WIDTH-bit ripple-carry adder built from 1-bit full-adder cells;
  - computes P + A_reg; the carry-out is unused.
- Controller FSM, counter and shift registers stay in imul_seq_ctrl.

## Test plan
- Reset abort: start 15×15, pull Reset low 2 cycles after the start edge → immediately oReady=1, oBusy=0, oDone=0, oResult=0; after release the block accepts 3×3 → oResult=9.
- Full-scale (macro off, WIDTH=4): 15×15 → oResult=225 (8'hE1), oDone rises exactly 4 cycles after the start edge.
- Hold/ack: 7×5 → oResult=35 (8'h23); iAck low 3 cycles → oDone and oResult stable; iAck high → oReady=1 next cycle, oResult still 35.
- Ignored start: start 6×6, pulse iStart with iA=2, iB=3 during RUN → oResult=36, exactly one completion.
- Early exit: 9×1 → 9 after 1 cycle with IMUL_EARLY_EXIT_EN, after 4 without; 0×0 → 0 after 1 cycle with, 4 without; 1×8 → 8 after 4 cycles in both builds.
- Back-to-back: ack 4×4, start 2×13 on the first IDLE cycle → oResult 16 then 26, no lost or duplicated oDone.
